instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of decode (ctrl_unit / register_bank) in the Risc-V datapath. Owns the program counter, issues word-addressed requests to an instruction memory with variable response latency, and buffers returned instructions with their PC in a small FIFO. The FIFO drives a valid/ready interface to decode. A redirect port from the branch/jump logic flushes the buffer, discards any in-flight response and restarts fetch at a new PC.

---
 rtl/instr_fetch.sv | 134 +++++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage feeding decode. Owns the program counter, issues
// word-addressed requests to an instruction memory whose response latency is
// variable (>= 1 cycle, in order), and buffers returned instructions together
// with their PC in a small FIFO presented to decode over valid/ready. A
// redirect from the branch/jump logic flushes the FIFO, discards any response
// still in flight and restarts fetch at the new PC.
//
// At most one memory request is outstanding at a time:
//   IDLE : nothing outstanding
//   WAIT : one outstanding, its response will be pushed into the FIFO
//   DROP : one outstanding, its response will be thrown away (post-redirect)
//
// Ports
//   clk            in   clock, rising-edge
//   rst            in   synchronous active-high reset
//   imem_req       out  request strobe (memory always accepts)
//   imem_addr      out  word address of the request (current pc)
//   imem_rvalid    in   response strobe
//   imem_rdata     in   instruction word of the response
//   instr_valid    out  FIFO head holds an instruction for decode
//   instr_ready    in   decode takes the head this cycle
//   instr          out  head instruction
//   instr_pc       out  PC of the head instruction
//   redirect_valid in   flush and restart fetch
//   redirect_pc    in   new fetch PC
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   req_pc;
    logic [XLEN-1:0]   buf_instr [DEPTH];
    logic [PC_W-1:0]   buf_pc    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic push;
    logic pop;

    assign full = (count == CNT_W'(DEPTH));

    // Outputs depend only on state/count and the redirect strobe; instr_ready
    // and imem_rvalid never reach an output combinationally.
    assign imem_req    = !rst && !redirect_valid && (state == IDLE) && !full;
    assign imem_addr   = pc;
    assign instr_valid = (count != '0) && !redirect_valid;
    assign instr       = buf_instr[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    // A kept response can never overflow the FIFO: a request is only issued
    // with room available and count cannot rise while it is outstanding.
    assign push = (state == WAIT) && imem_rvalid && !redirect_valid && !rst;
    assign pop  = instr_valid && instr_ready;

    // FIFO storage carries no reset; count and pointers qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            // An outstanding response must still be absorbed, but its data is
            // stale; unless it arrives right now, remember to discard it.
            case (state)
                WAIT, DROP: state <= imem_rvalid ? IDLE : DROP;
                default:    state <= IDLE;
            endcase
        end else begin
            if (imem_req) begin
                req_pc <= pc;
                pc     <= pc + PC_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // A response seen in IDLE belongs to a request issued before reset.
            case (state)
                IDLE:       state <= imem_req ? WAIT : IDLE;
                WAIT, DROP: state <= imem_rvalid ? IDLE : state;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Drives instr_fetch with a behavioural instruction memory (random latency,
// one response per request) and compares every cycle against a reference
// model built from a queue of expected buffered instructions plus a record of
// the single outstanding request. Directed scenarios come first, followed by
// a randomized run with random ready, redirects and resets.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int         XLEN     = 32;
    localparam int         PC_W     = 8;
    localparam int         DEPTH    = 2;
    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    always #5 clk = ~clk;

    instr_fetch #(
        .XLEN(XLEN), .PC_W(PC_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // behavioural memory
    logic [31:0] mem [256];
    bit          mem_pending = 0;
    int          mem_cnt = 0;
    logic [7:0]  mem_addr = '0;
    int          lat_min = 1;
    int          lat_max = 1;

    // reference model
    bit          m_known = 0;
    bit          m_out = 0;
    bit          m_keep = 0;
    logic [7:0]  m_pc = '0;
    logic [7:0]  m_reqpc = '0;
    ent_t        q[$];

    // observed deliveries (instr_valid && instr_ready)
    logic [7:0]  dlv_pc[$];
    logic [31:0] dlv_ins[$];

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit rd, input logic [7:0] rpc, input bit rdy);
        bit          exp_req, exp_vld, rv, pop_e, push_e, obs_req;
        logic [7:0]  obs_addr;
        logic [31:0] rdat;
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        rv             = mem_pending && (mem_cnt == 0);
        rdat           = rv ? mem[mem_addr] : $urandom;
        imem_rvalid    = rv;
        imem_rdata     = rdat;
        #1;
        exp_req = !r && !rd && m_known && !m_out && (q.size() < DEPTH);
        exp_vld = (q.size() != 0) && !rd;
        check("imem_req", imem_req, exp_req);
        if (m_known) begin
            check("imem_addr", imem_addr, m_pc);
            check("instr_valid", instr_valid, exp_vld);
            if (exp_vld) begin
                check("instr", instr, q[0].ins);
                check("instr_pc", instr_pc, q[0].pc);
            end
        end
        if (instr_valid && rdy) begin
            dlv_pc.push_back(instr_pc);
            dlv_ins.push_back(instr);
        end
        obs_req  = imem_req;
        obs_addr = imem_addr;
        @(posedge clk);
        if (r) begin
            m_known = 1;
            m_pc    = RESET_PC;
            m_out   = 0;
            m_keep  = 0;
            q.delete();
        end else if (rd) begin
            q.delete();
            m_pc = rpc;
            if (m_out && rv) m_out = 0;
            else if (m_out) m_keep = 0;
        end else begin
            pop_e  = (q.size() != 0) && rdy;
            push_e = m_out && m_keep && rv;
            if (m_out && rv) m_out = 0;
            if (pop_e) void'(q.pop_front());
            if (push_e) q.push_back(ent_t'{rdat, m_reqpc});
            if (exp_req) begin
                m_out   = 1;
                m_keep  = 1;
                m_reqpc = m_pc;
                m_pc    = m_pc + 8'd1;
            end
        end
        if (rv) mem_pending = 0;
        else if (mem_pending) mem_cnt--;
        if (obs_req) begin
            mem_pending = 1;
            mem_addr    = obs_addr;
            mem_cnt     = $urandom_range(lat_max, lat_min) - 1;
        end
        #1;
    endtask

    // A response left over from before reset lands no later than the first
    // cycle after rst falls, while the fetch stage is still IDLE.
    task automatic do_reset(input int n);
        if (mem_pending && mem_cnt > n) mem_cnt = n;
        repeat (n) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        bit found;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h13 + i;

        // reset, then streaming with L=1 and decode always ready
        lat_min = 1; lat_max = 1;
        do_reset(2);
        dlv_pc.delete(); dlv_ins.delete();
        repeat (12) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("stream_count", dlv_pc.size(), 32'd5);
        if (dlv_ins.size() >= 3) begin
            check("stream_i0", dlv_ins[0], 32'h13);
            check("stream_i1", dlv_ins[1], 32'h14);
            check("stream_i2", dlv_ins[2], 32'h15);
            check("stream_pc2", dlv_pc[2], 32'h2);
        end

        // decode stalls: FIFO fills, then drains in order
        do_reset(2);
        dlv_pc.delete(); dlv_ins.delete();
        repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (8) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        if (dlv_pc.size() >= 3) begin
            check("stall_pc0", dlv_pc[0], 32'h0);
            check("stall_pc1", dlv_pc[1], 32'h1);
            check("stall_pc2", dlv_pc[2], 32'h2);
        end else check("stall_count", dlv_pc.size(), 32'd3);

        // redirect to 0x40 while the request to address 5 is outstanding (L=3)
        do_reset(2);
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_out && m_reqpc == 8'h05) found = 1;
            else cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("reach_addr5", found, 1'b1);
        cycle(1'b0, 1'b1, 8'h40, 1'b1);
        dlv_pc.delete(); dlv_ins.delete();
        repeat (20) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        if (dlv_pc.size() >= 1) check("redir_first_pc", dlv_pc[0], 32'h40);
        else check("redir_count", dlv_pc.size(), 32'd1);

        // redirect in the same cycle the response arrives
        lat_min = 2; lat_max = 2;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mem_pending && mem_cnt == 0 && m_out && m_keep) found = 1;
            else cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("reach_rvalid", found, 1'b1);
        cycle(1'b0, 1'b1, 8'h20, 1'b1);
        dlv_pc.delete(); dlv_ins.delete();
        repeat (12) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        if (dlv_pc.size() >= 1) check("same_cyc_first_pc", dlv_pc[0], 32'h20);
        else check("same_cyc_count", dlv_pc.size(), 32'd1);

        // PC wrap-around
        lat_min = 1; lat_max = 1;
        cycle(1'b0, 1'b1, 8'hFE, 1'b1);
        dlv_pc.delete(); dlv_ins.delete();
        repeat (14) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        if (dlv_pc.size() >= 4) begin
            check("wrap_pc0", dlv_pc[0], 32'hFE);
            check("wrap_pc1", dlv_pc[1], 32'hFF);
            check("wrap_pc2", dlv_pc[2], 32'h00);
            check("wrap_pc3", dlv_pc[3], 32'h01);
        end else check("wrap_count", dlv_pc.size(), 32'd4);

        // reset mid-WAIT; stale response lands in the first cycle after reset
        lat_min = 4; lat_max = 4;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_pending && mem_cnt >= 2) found = 1;
            else cycle(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check("reach_wait", found, 1'b1);
        mem_cnt = 2;
        do_reset(2);
        lat_min = 1; lat_max = 1;
        dlv_pc.delete(); dlv_ins.delete();
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        if (dlv_pc.size() >= 1) check("post_rst_pc", dlv_pc[0], RESET_PC);
        else check("post_rst_count", dlv_pc.size(), 32'd1);

        // randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            int x;
            x = $urandom_range(99);
            if (x < 2) do_reset(2);
            else cycle(1'b0, x < 8, 8'($urandom), $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
